// File: rtl/imem_loader.sv
// imem_loader: assembles a host byte stream into 32-bit words and writes them into the instruction RAM
//   clk, rst (async, active-low)
//   start, word_count (0 = full depth) : begin a load from IDLE/DONE
//   byte_in, byte_valid, byte_ready    : byte stream handshake
//   we, wa, wd                         : imem write port, one pulse per word
//   busy, done, cpu_hold, err          : status; cpu_hold holds the core in reset while loading
//   IMEM_LOADER_CHECKSUM_EN            : adds a trailing XOR checksum byte and err reporting
module imem_loader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              err
);
    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;
    state_t            state, nxt;
    logic [1:0]        bidx, lane;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              take, idle_like;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        acc;
    localparam state_t FINAL = CHECK;
`else
    localparam state_t FINAL = DONE;
    assign err = 1'b0;
`endif
    assign take      = byte_valid && byte_ready;
    assign idle_like = (state == IDLE) || (state == DONE);
    assign lane      = (BIG_ENDIAN != 0) ? 2'd3 - bidx : bidx;
    assign we        = (state == WRITE);
    assign wa        = addr;
    assign done      = (state == DONE);
    assign cpu_hold  = busy;
    always_comb begin
        asm_d = asm_q;
        asm_d[{lane, 3'b000} +: 8] = byte_in;
    end
    always_comb begin
        nxt        = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: nxt = start ? LOAD : state;
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                nxt        = (take && bidx == 2'd3) ? WRITE : LOAD;
            end
            WRITE: begin
                busy = 1'b1;
                nxt  = (remaining == (ADDR_W+1)'(1)) ? FINAL : LOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                nxt        = take ? DONE : CHECK;
            end
`endif
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bidx      <= '0;
            remaining <= '0;
            addr      <= '0;
            asm_q     <= '0;
            wd        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (idle_like && start) begin
                remaining <= (word_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : word_count;
                addr      <= '0;
                bidx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc       <= '0;
                err       <= 1'b0;
`endif
            end
            if (state == LOAD && take) begin
                asm_q <= asm_d;
                bidx  <= bidx + 2'd1;
                // wd is only updated when a word completes so it holds between writes
                if (bidx == 2'd3)
                    wd <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc <= acc ^ byte_in;
`endif
            end
            if (state == WRITE) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == CHECK && take)
                err <= (byte_in != acc);
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed loads checked against a word-list model of the byte stream
module tb_imem_loader;
    logic        clk, rst, start, byte_valid;
    logic [6:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_ready, we, busy, done, cpu_hold, err;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        le_byte_ready, le_we, le_busy, le_done, le_cpu_hold, le_err;
    logic [5:0]  le_wa;
    logic [31:0] le_wd;
    int          n_checks = 0, n_fail = 0;
    logic [7:0]  stream[$];
    logic [5:0]  got_a[$], got_la[$];
    logic [31:0] got_d[$], got_le[$];

    imem_loader #(.ADDR_W(6), .DATA_W(32), .BIG_ENDIAN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
        .cpu_hold(cpu_hold), .err(err));

    imem_loader #(.ADDR_W(6), .DATA_W(32), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(le_byte_ready),
        .we(le_we), .wa(le_wa), .wd(le_wd), .busy(le_busy), .done(le_done),
        .cpu_hold(le_cpu_hold), .err(le_err));

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            got_a.push_back(wa);
            got_d.push_back(wd);
        end
        if (le_we) begin
            got_la.push_back(le_wa);
            got_le.push_back(le_wd);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_got();
        got_a.delete(); got_d.delete(); got_la.delete(); got_le.delete();
    endtask

    function automatic logic [7:0] xor_stream();
        logic [7:0] x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        return x;
    endfunction

    task automatic fill_random(input int nbytes);
        stream.delete();
        repeat (nbytes) stream.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int stalls);
        bit ok = 0;
        byte_valid = 0;
        repeat (stalls) begin @(posedge clk); #1; end
        byte_valid = 1;
        byte_in    = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        byte_valid = 0;
        chk("byte handshake", 32'(ok), 32'd1);
    endtask

    // Model: word w of a load is stream bytes 4w..4w+3, written at address w mod 64.
    task automatic run_load(input int wc, input int stall_mode, input bit mid_start, input logic [7:0] ck);
        int          n;
        logic [31:0] be, le;
        logic        exp_err;
        n = (wc == 0) ? 64 : wc;
        clear_got();
        @(posedge clk); #1;
        start = 1; word_count = wc[6:0]; byte_valid = 1; byte_in = 8'hEE;
        @(posedge clk); #1;
        start = 0; byte_valid = 0;
        chk("busy after start", 32'({busy, cpu_hold, done, byte_ready}), 32'b1101);
        for (int i = 0; i < 4 * n; i++) begin
            if (mid_start && i == 100) begin
                start = 1; word_count = 7'd3;
                @(posedge clk); #1;
                start = 0;
            end
            send_byte(stream[i], stall_mode == 0 ? 0 : stall_mode == 2 ? 2 : int'($urandom_range(0, 2)));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(ck, 0);
        exp_err = (ck != xor_stream());
`else
        exp_err = 1'b0;
`endif
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("write count", 32'(got_d.size()), 32'(n));
        chk("le write count", 32'(got_le.size()), 32'(n));
        for (int w = 0; w < n && w < got_d.size() && w < got_le.size(); w++) begin
            be = {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
            le = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            chk($sformatf("wa[%0d]", w), 32'(got_a[w]), 32'(w % 64));
            chk($sformatf("wd_be[%0d]", w), got_d[w], be);
            chk($sformatf("wa_le[%0d]", w), 32'(got_la[w]), 32'(w % 64));
            chk($sformatf("wd_le[%0d]", w), got_le[w], le);
        end
        be = {stream[4*n-4], stream[4*n-3], stream[4*n-2], stream[4*n-1]};
        chk("final status", 32'({done, busy, cpu_hold, byte_ready, we}), 32'b10000);
        chk("le final status", 32'({le_done, le_busy, le_cpu_hold, le_byte_ready, le_we}), 32'b10000);
        chk("wa after done", 32'(wa), 32'(n % 64));
        chk("wd holds", wd, be);
        chk("err", 32'(err), 32'(exp_err));
        chk("le err", 32'(le_err), 32'(exp_err));
    endtask

    initial begin
        rst = 0; start = 0; word_count = '0; byte_in = '0; byte_valid = 0;
        repeat (2) @(posedge clk); #1;
        chk("reset flags", 32'({we, byte_ready, busy, done, cpu_hold, err, wa}), 32'd0);
        chk("reset wd", wd, 32'd0);
        @(negedge clk) rst = 1;
        // abandon a load after two bytes
        clear_got();
        @(posedge clk); #1;
        start = 1; word_count = 7'd2;
        @(posedge clk); #1;
        start = 0;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst = 0;
        #1;
        chk("mid-load reset flags", 32'({we, byte_ready, busy, done, cpu_hold, err, wa}), 32'd0);
        chk("mid-load reset wd", wd, 32'd0);
        chk("no write before reset", 32'(got_d.size()), 32'd0);
        @(negedge clk) rst = 1;
        stream = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, 8'h04);
        stream = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h07};
        run_load(2, 0, 0, 8'h03);
        stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, 2, 0, 8'h00);
        fill_random(256);
        run_load(0, 1, 1, xor_stream());
        repeat (3) begin
            int wc;
            wc = int'($urandom_range(1, 6));
            fill_random(4 * wc);
            run_load(wc, 1, 0, xor_stream());
        end
        stream = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, 8'h05);
        run_load(1, 0, 0, 8'h04);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: receives a byte stream from a host or debug link, assembles 32-bit instruction words and writes them into a writable instruction RAM.
- The RAM has the same 64 x 32 word organisation and 6-bit word address as the CPU-side read port.
- Sits between the host byte link and the imem write port.
- Holds the MIPS core in reset (cpu_hold) while a program is being loaded.

Parameters:
- ADDR_W, 6: word-address width; depth = 2**ADDR_W words.
- DATA_W, 32: instruction word width; fixed at 4 bytes.
- BIG_ENDIAN, 1: 1 = first byte received goes to wd[31:24]; 0 = first byte goes to wd[7:0].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- word_count  in  ADDR_W+1  number of words to load; 0 is treated as 2**ADDR_W.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  imem write enable; one-cycle pulse per word.
- wa  out  ADDR_W  imem write word address.
- wd  out  DATA_W  imem write data.
- busy  out  1  load in progress (LOAD, WRITE, CHECK states).
- done  out  1  level; set when the load completes, cleared by the next accepted start.
- cpu_hold  out  1  equals busy; the core is held in reset while it is 1.
- err  out  1  checksum mismatch; tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - Outputs: we=0, wa=0, wd=0, byte_ready=0, busy=0, done=0, cpu_hold=0, err=0.
  - Internal registers: byte index = 0, word counter = 0, checksum accumulator = 0.
  - Reset mid-load abandons the load. Words already written remain in imem, and the partial word is discarded.
- States: IDLE, LOAD, WRITE, DONE, CHECK (CHECK exists only with the optional feature).
- IDLE / DONE, start=1:
  - Latch remaining = word_count (0 maps to 64).
  - addr = 0, byte index = 0, done = 0, err = 0, accumulator = 0.
  - Next state = LOAD.
- LOAD:
  - byte_ready = 1. A byte is accepted in any cycle where byte_valid and byte_ready are both 1.
  - The accepted byte is placed into its lane per BIG_ENDIAN, and byte index increments.
  - On acceptance of the 4th byte: byte index goes to 0 and next state = WRITE.
  - byte_valid=0 stalls indefinitely with no timeout; state and partial word are held.
- WRITE (exactly one cycle):
  - byte_ready = 0, we = 1, wa = addr, wd = assembled word.
  - Next cycle: addr += 1 (wraps modulo 64) and remaining -= 1.
  - If remaining reaches 0: next state = DONE, or CHECK when the feature is enabled. Otherwise next state = LOAD.
- DONE:
  - done = 1, busy = 0, byte_ready = 0.
  - wa holds the last-written address + 1.
- Latency: we asserts on the cycle after the clock edge that accepts the 4th byte of a word. Minimum throughput is 5 cycles per word.
- start while busy is ignored.
- start with byte_valid=1 in the same cycle: the byte is not accepted, because byte_ready is 0 in IDLE and DONE.
- Full-depth load (word_count = 0 or 64): writes addresses 0..63. The final addr increment wraps to 0, which is harmless.
- wd holds its last value when we = 0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Every accepted data byte is XORed into an 8-bit accumulator.
  - After the last WRITE, the FSM enters CHECK with byte_ready = 1 and accepts exactly one checksum byte.
  - err = 1 if the checksum byte != accumulator, else err = 0.
  - Then next state = DONE. done asserts regardless of err.
- Not defined: no CHECK state, no accumulator, err is constant 0, and the stream carries data bytes only.

Test Plan:
- Reset: hold rst=0 mid-LOAD after 2 bytes, then release → all outputs 0, state IDLE; a following 1-word load of 01,02,03,04 writes wa=0, wd=32'h01020304.
- Load of 2 words with BIG_ENDIAN=1: bytes 20,02,00,05,20,03,00,07 → we pulses twice, at wa=0 wd=32'h20020005 and wa=1 wd=32'h20030007; done=1, busy=0.
- Backpressure: byte_valid toggled 1,0,0,1,... during a 1-word load → only handshaked bytes are captured; wd is correct; exactly one we pulse.
- word_count = 0 → 64 writes covering addresses 0..63; done after the 64th; start pulsed mid-load has no effect.
- BIG_ENDIAN=0: bytes AA,BB,CC,DD → wd = 32'hDDCCBBAA.
- Checksum (macro defined): bytes 01,02,03,04 then checksum 04 → err=0, done=1. Same load with checksum 05 → err=1, done=1.
